// File: rtl/m_div_sequencer.sv
// RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU): radix-2 restoring division over XLEN cycles.
// Optional M_DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module m_div_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            is_rem_q, is_rem_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;

   logic            accept;
   logic            is_signed;
   logic            sign_a, sign_b;
   logic            div_zero, overflow, early_out, special;
   logic [XLEN-1:0] abs_a, abs_b;
   logic [XLEN:0]   rem_shift, trial;
   logic [XLEN-1:0] fix_quo, fix_rem;

   // Accept-time decode of operands and special cases
   always_comb begin
      accept    = start & func3[2] & ~flush & ((state_q == S_IDLE) || (state_q == S_DONE));
      is_signed = ~func3[0];
      sign_a    = is_signed & rs1_val[XLEN-1];
      sign_b    = is_signed & rs2_val[XLEN-1];
      abs_a     = sign_a ? -rs1_val : rs1_val;
      abs_b     = sign_b ? -rs2_val : rs2_val;
      div_zero  = (rs2_val == '0);
      overflow  = is_signed & (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_val == '1);
`ifdef M_DIV_EARLY_OUT_EN
      early_out = ~div_zero & (abs_a < abs_b);
`else
      early_out = 1'b0;
`endif
      special   = div_zero | overflow | early_out;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush wins over everything, accept already excludes flush
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_CALC:  state_d = (cnt_q == '0) ? S_FIX : S_CALC;
         S_FIX:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         state_d = special ? S_DONE : S_CALC;
      end
      if (flush) begin
         state_d = S_IDLE;
      end
   end

   // Output logic
   always_comb begin
      busy   = (state_q == S_CALC) || (state_q == S_FIX);
      done   = (state_q == S_DONE);
      result = result_q;
   end

   // Datapath next values
   always_comb begin
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      result_d  = result_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;

      // The shifted partial remainder needs XLEN+1 bits; the trial borrow is its MSB
      rem_shift = {1'b0, rem_q[XLEN-1:0], quo_q[XLEN-1]} ;
      trial     = rem_shift - {1'b0, dvs_q};
      fix_quo   = neg_quo_q ? -quo_q : quo_q;
      fix_rem   = neg_rem_q ? -rem_q : rem_q;

      if (flush) begin
         cnt_d = cnt_q;
      end else if (accept) begin
         is_rem_d  = func3[1];
         neg_quo_d = sign_a ^ sign_b;
         neg_rem_d = sign_a;
         dvs_d     = abs_b;
         quo_d     = abs_a;
         rem_d     = '0;
         cnt_d     = CW'(XLEN - 1);
         if (div_zero) begin
            result_d = func3[1] ? rs1_val : '1;
         end else if (overflow) begin
            result_d = func3[1] ? '0 : rs1_val;
         end else if (early_out) begin
            result_d = func3[1] ? rs1_val : '0;
         end
      end else if (state_q == S_CALC) begin
         cnt_d = cnt_q - 1'b1;
         if (trial[XLEN]) begin
            rem_d = rem_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
         end else begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
         end
      end else if (state_q == S_FIX) begin
         result_d = is_rem_q ? fix_rem : fix_quo;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         result_q  <= result_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

endmodule
